// File: rtl/mips16_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips16_ctrl_pkg
//   Shared constants for the multi-cycle 16-bit MIPS control unit:
//   4-bit state encodings, opcode values (IR[15:12]), ALU operation codes,
//   ALU B-operand select codes, PC source codes, and an opcode classifier.
// ---------------------------------------------------------------------------
package mips16_ctrl_pkg;

   // State encodings. The debug port exposes these, so keep them stable.
   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_FETCH     = 4'd1;
   localparam logic [3:0] ST_DECODE    = 4'd2;
   localparam logic [3:0] ST_R_EXEC    = 4'd3;
   localparam logic [3:0] ST_R_WB      = 4'd4;
   localparam logic [3:0] ST_I_EXEC    = 4'd5;
   localparam logic [3:0] ST_I_WB      = 4'd6;
   localparam logic [3:0] ST_MEM_ADDR  = 4'd7;
   localparam logic [3:0] ST_MEM_READ  = 4'd8;
   localparam logic [3:0] ST_MEM_WB    = 4'd9;
   localparam logic [3:0] ST_MEM_WRITE = 4'd10;
   localparam logic [3:0] ST_BRANCH    = 4'd11;
   localparam logic [3:0] ST_TRAP      = 4'd12;

   // Opcodes. 0000-0011 and 0111 form the register-register group whose
   // ALU function comes from IR[14:12].
   localparam logic [3:0] OP_R0   = 4'b0000;
   localparam logic [3:0] OP_R1   = 4'b0001;
   localparam logic [3:0] OP_R2   = 4'b0010;
   localparam logic [3:0] OP_R3   = 4'b0011;
   localparam logic [3:0] OP_R7   = 4'b0111;
   localparam logic [3:0] OP_ADDI = 4'b0100;
   localparam logic [3:0] OP_LW   = 4'b0101;
   localparam logic [3:0] OP_SW   = 4'b0110;
   localparam logic [3:0] OP_BEQ  = 4'b1000;

   // alu_op codes
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // alu_src_b codes
   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_INC  = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BOFF = 2'b11;

   // pc_source codes
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

   typedef enum logic [2:0] {
      CLS_R,
      CLS_I,
      CLS_LW,
      CLS_SW,
      CLS_BEQ,
      CLS_ILLEGAL
   } op_class_t;

   function automatic op_class_t op_class(input logic [3:0] op);
      op_class_t cls;
      cls = CLS_ILLEGAL;
      if (op == OP_R0 || op == OP_R1 || op == OP_R2 || op == OP_R3 || op == OP_R7)
         cls = CLS_R;
      else if (op == OP_ADDI)
         cls = CLS_I;
      else if (op == OP_LW)
         cls = CLS_LW;
      else if (op == OP_SW)
         cls = CLS_SW;
      else if (op == OP_BEQ)
         cls = CLS_BEQ;
      return cls;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
//   Counts cycles a memory request has waited for mem_ready and flags a
//   timeout when the count has reached WAIT_LIMIT with still no ready.
//   WAIT_LIMIT = 0 disables the timeout (counter simply saturates).
// Ports:
//   clock      in  system clock
//   reset_n    in  synchronous active-low reset
//   clear      in  restart count (state is changing)
//   active     in  a memory request is outstanding this cycle
//   mem_ready  in  memory completes the request this cycle
//   timeout    out request has expired this cycle (combinational)
// ---------------------------------------------------------------------------
module mem_wait_timer #(
   parameter int WAIT_LIMIT = 8
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic active,
   input  logic mem_ready,
   output logic timeout
);

   localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
   // With the timeout disabled the counter parks at all-ones instead.
   localparam logic [CW-1:0] SAT = (WAIT_LIMIT == 0) ? '1 : CW'(WAIT_LIMIT);

   logic [CW-1:0] count;

   always_ff @(posedge clock) begin
      if (!reset_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (active && !mem_ready && count != SAT)
         count <= count + CW'(1);
   end

   // Ready in the same cycle the limit is reached takes priority.
   assign timeout = (WAIT_LIMIT != 0) && active && !mem_ready && (count == SAT);

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Control FSM for the multi-cycle 16-bit MIPS datapath. Decodes IR[15:12]
//   and sequences PC/IR/register-file/ALU-mux/memory strobes one step per
//   cycle, handshaking with the unified memory port and timing out stalled
//   requests.
// Configuration macro:
//   MC_ILLEGAL_TRAP_EN  defined: illegal opcode enters TRAP (trap=1, all
//                       strobes 0, left only by reset). Undefined: illegal
//                       opcode is a NOP that completes in DECODE.
// Parameters:
//   WAIT_LIMIT     max wait cycles per memory request; 0 = no timeout
// Ports:
//   clock, reset_n               clock, synchronous active-low reset
//   run                          execute enable, sampled at boundaries
//   opcode, zero, mem_ready      IR[15:12], ALU zero flag, memory done
//   mem_rd, mem_wr, iord         memory request strobes / address select
//   ir_write, pc_write,
//   pc_write_cond, pc_source     IR / PC load controls
//   reg_dst, reg_write,
//   mem_to_reg                   register-file write controls
//   alu_src_a, alu_src_b, alu_op ALU operand / operation selects
//   instr_done, bus_err          completion pulse, timeout pulse
//   state                        current state (debug)
//   trap                         (macro only) stuck on illegal opcode
// ---------------------------------------------------------------------------
module multicycle_control
   import mips16_ctrl_pkg::*;
#(
   parameter int WAIT_LIMIT = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       run,
   input  logic [3:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_source,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       instr_done,
   output logic       bus_err,
   output logic [3:0] state
`ifdef MC_ILLEGAL_TRAP_EN
   ,
   output logic       trap
`endif
);

   logic [3:0] next_state;
   logic [3:0] boundary_next;
   logic       req_active;
   logic       timeout;
   op_class_t  cls;

   // The branch decision (zero) is folded into the PC enable by the
   // datapath; the FSM raises pc_write_cond regardless of the flag.
   logic unused_zero;
   assign unused_zero = zero;

   assign cls           = op_class(opcode);
   assign boundary_next = run ? ST_FETCH : ST_IDLE;
   assign req_active    = (state == ST_FETCH) || (state == ST_MEM_READ) ||
                          (state == ST_MEM_WRITE);

   mem_wait_timer #(
      .WAIT_LIMIT (WAIT_LIMIT)
   ) u_timer (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear     (next_state != state),
      .active    (req_active),
      .mem_ready (mem_ready),
      .timeout   (timeout)
   );

   // NOTE: registered state uses non-blocking assignment so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clock) begin
      if (!reset_n)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:      if (run) next_state = ST_FETCH;
         ST_FETCH: begin
            if (mem_ready)    next_state = ST_DECODE;
            else if (timeout) next_state = ST_IDLE;
         end
         ST_DECODE: begin
            case (cls)
               CLS_R:        next_state = ST_R_EXEC;
               CLS_I:        next_state = ST_I_EXEC;
               CLS_LW,
               CLS_SW:       next_state = ST_MEM_ADDR;
               CLS_BEQ:      next_state = ST_BRANCH;
`ifdef MC_ILLEGAL_TRAP_EN
               default:      next_state = ST_TRAP;
`else
               default:      next_state = boundary_next;
`endif
            endcase
         end
         ST_R_EXEC:    next_state = ST_R_WB;
         ST_I_EXEC:    next_state = ST_I_WB;
         ST_MEM_ADDR:  next_state = (cls == CLS_LW) ? ST_MEM_READ : ST_MEM_WRITE;
         ST_MEM_READ: begin
            if (mem_ready)    next_state = ST_MEM_WB;
            else if (timeout) next_state = ST_IDLE;
         end
         ST_MEM_WRITE: begin
            if (mem_ready)    next_state = boundary_next;
            else if (timeout) next_state = ST_IDLE;
         end
         ST_R_WB,
         ST_I_WB,
         ST_MEM_WB,
         ST_BRANCH:    next_state = boundary_next;
         ST_TRAP:      next_state = ST_TRAP;
         default:      next_state = ST_IDLE;
      endcase
   end

   // Outputs follow the state; the reset_n gate keeps every strobe low in
   // the reset cycle itself, so a pending request is dropped immediately.
   always_comb begin
      // NOTE: every output gets a default before the case so no path through
      // the block leaves a signal unassigned (which would infer a latch).
      mem_rd        = 1'b0;
      mem_wr        = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = PCSRC_ALU;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      alu_op        = ALU_ADD;
      instr_done    = 1'b0;
      bus_err       = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
      trap          = 1'b0;
`endif
      if (reset_n) begin
         case (state)
            ST_FETCH: begin
               mem_rd    = !timeout;
               alu_src_b = SRCB_INC;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
               bus_err   = timeout;
            end
            ST_DECODE: begin
               alu_src_b = SRCB_BOFF;
`ifndef MC_ILLEGAL_TRAP_EN
               instr_done = (cls == CLS_ILLEGAL);
`endif
            end
            ST_R_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
               reg_dst    = 1'b1;
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            ST_I_EXEC,
            ST_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
            end
            ST_I_WB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            ST_MEM_READ: begin
               mem_rd  = !timeout;
               iord    = 1'b1;
               bus_err = timeout;
            end
            ST_MEM_WB: begin
               mem_to_reg = 1'b1;
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            ST_MEM_WRITE: begin
               mem_wr     = !timeout;
               iord       = 1'b1;
               instr_done = mem_ready;
               bus_err    = timeout;
            end
            ST_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = ALU_SUB;
               pc_write_cond = 1'b1;
               pc_source     = PCSRC_ALUOUT;
               instr_done    = 1'b1;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            ST_TRAP:  trap = 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule
